// File: rtl/tpram_pkg.sv
// tpram_pkg: shared FSM state type and byte-merge helper for tpram_init
package tpram_pkg;
  localparam int MAX_W = 1024;
  localparam int BYTES = MAX_W / 8;
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  // bytes whose wen_n bit is low take nw, others keep old; callers zero-extend narrower words
  function automatic logic [MAX_W-1:0] merge(input logic [MAX_W-1:0] old, input logic [MAX_W-1:0] nw, input logic [BYTES-1:0] wen_n);
    logic [MAX_W-1:0] r;
    r = old;
    for (int i = 0; i < BYTES; i++) r[i*8 +: 8] = wen_n[i] ? old[i*8 +: 8] : nw[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/tpram_clr_seq.sv
// tpram_clr_seq: clear sequencer FSM, fill-address counter and write-port mux
// CLK/RSTN clock and async active-low reset; CLR restarts the fill
// CENB/AB/DB/WENB port B write request; busy high while filling
// we/wa/wd/wm the write actually applied to the array (sequencer or port B)
module tpram_clr_seq import tpram_pkg::*; #(
  parameter int DW = 32,
  parameter int DEPTH = 1024,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     CLR,
  input  logic                     CENB,
  input  logic [$clog2(DEPTH)-1:0] AB,
  input  logic [DW-1:0]            DB,
  input  logic [DW/8-1:0]          WENB,
  output logic                     busy,
  output logic                     we,
  output logic [$clog2(DEPTH)-1:0] wa,
  output logic [DW-1:0]            wd,
  output logic [DW/8-1:0]          wm
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state <= ST_CLEAR;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = CLR ? ST_CLEAR : (state == ST_CLEAR && cnt == AW'(DEPTH - 1)) ? ST_READY : state;
    cnt_nx = (CLR || state == ST_READY) ? '0 : cnt + 1'b1;
  end
  always_comb begin
    busy = state == ST_CLEAR;
    we = busy | ~CENB;
    wa = busy ? cnt : AB;
    wd = busy ? INIT_VALUE : DB;
    wm = busy ? '0 : WENB;
  end
endmodule

// File: rtl/tpram_init.sv
// tpram_init: two-port RAM with byte-masked writes, 1/2-cycle reads and a hardware clear fill
// CLK/RSTN clock and async active-low reset; CLR re-runs the fill with INIT_VALUE
// CENA/AA -> QA/QVALIDA read port A; CENB/AB/DB/WENB write port B (active-low enables/mask)
// BUSY high while the fill owns the array
// TPRAM_INIT_BYPASS_EN: same-cycle same-address read returns the merged new word
module tpram_init import tpram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int READ_LAT = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter string RAM_STYLE_VAL = "block"
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      CLR,
  input  logic                      CENA,
  input  logic [$clog2(DEPTH)-1:0]  AA,
  output logic [DATA_WIDTH-1:0]     QA,
  output logic                      QVALIDA,
  input  logic                      CENB,
  input  logic [$clog2(DEPTH)-1:0]  AB,
  input  logic [DATA_WIDTH-1:0]     DB,
  input  logic [DATA_WIDTH/8-1:0]   WENB,
  output logic                      BUSY
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_WIDTH / 8;
  (* ram_style = RAM_STYLE_VAL *) logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic busy, we, rd, v1;
  logic [AW-1:0] wa;
  logic [DATA_WIDTH-1:0] wd, rdat, q1;
  logic [NB-1:0] wm;
  tpram_clr_seq #(.DW(DATA_WIDTH), .DEPTH(DEPTH), .INIT_VALUE(INIT_VALUE)) u_seq (
    .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .CENB(CENB), .AB(AB), .DB(DB), .WENB(WENB),
    .busy(busy), .we(we), .wa(wa), .wd(wd), .wm(wm)
  );
  assign BUSY = busy;
  assign rd = ~busy & ~CENA;
  always_ff @(posedge CLK)
    if (we)
      for (int i = 0; i < NB; i++)
        if (!wm[i]) mem[wa][i*8 +: 8] <= wd[i*8 +: 8];
`ifdef TPRAM_INIT_BYPASS_EN
  // reads only happen outside the fill, so a colliding write here is always port B
  always_comb rdat = (we && wa == AA) ? DATA_WIDTH'(merge(MAX_W'(mem[AA]), MAX_W'(wd), BYTES'(wm))) : mem[AA];
`else
  always_comb rdat = mem[AA];
`endif
  // QA holds between reads, so the data register only loads on an accepted read
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd;
      if (rd) q1 <= rdat;
    end
  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] q2;
      logic v2;
      always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
          q2 <= '0;
          v2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) q2 <= q1;
        end
      assign QA = q2;
      assign QVALIDA = v2;
    end else begin : g_lat1
      assign QA = q1;
      assign QVALIDA = v1;
    end
  endgenerate
endmodule
